// File: rtl/food_spawner.sv
// Draws random grid cells from the PRBS stream, rejects off-grid draws, checks
// occupancy with the snake body store and commits the first free cell found.
module food_spawner #(
  parameter int COLS      = 32,
  parameter int ROWS      = 24,
  parameter int XB        = 5,
  parameter int YB        = 5,
  parameter int MAX_TRIES = 64
) (
  input  logic          clock_25,
  input  logic          reset,
  input  logic [6:0]    rnd,
  input  logic          spawn_req,
  output logic          occ_req,
  output logic [XB-1:0] occ_x,
  output logic [YB-1:0] occ_y,
  input  logic          occ_ack,
  input  logic          occ_hit,
  output logic          busy,
  output logic [XB-1:0] food_x,
  output logic [YB-1:0] food_y,
  output logic          food_valid,
  output logic          food_done,
  output logic          food_fail
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_X = 3'd1,
    GET_Y = 3'd2,
    QUERY = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } state_t;

  localparam logic [XB:0] COLS_L = (XB+1)'(COLS);
  localparam logic [YB:0] ROWS_L = (YB+1)'(ROWS);
  localparam logic [7:0]  MAX_L  = 8'(MAX_TRIES);

  state_t          state_q, state_d;
  logic [7:0]      tries_q, tries_d;
  logic [XB-1:0]   cand_x_q, cand_x_d;
  logic [YB-1:0]   cand_y_q, cand_y_d;
  logic            bump_s;
  logic            occ_req_q, busy_q, done_q, fail_q, valid_q;
  logic [XB-1:0]   food_x_q;
  logic [YB-1:0]   food_y_q;

  // Next-state, candidate capture and retry accounting.
  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    bump_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (spawn_req) begin
          state_d = GET_X;
          tries_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      GET_X: begin
        cand_x_d = rnd[XB-1:0];
        if ({1'b0, rnd[XB-1:0]} < COLS_L) begin
          state_d = GET_Y;
        end else begin
          bump_s = 1'b1;
        end
      end
      GET_Y: begin
        cand_y_d = rnd[YB-1:0];
        if ({1'b0, rnd[YB-1:0]} < ROWS_L) begin
          state_d = QUERY;
        end else begin
          bump_s = 1'b1;
        end
      end
      QUERY: begin
        if (occ_ack && !occ_hit) begin
          state_d = DONE;
        end else if (occ_ack && occ_hit) begin
          state_d = GET_X;
          bump_s  = 1'b1;
        end else begin
          state_d = QUERY;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A retry that exhausts the budget overrides whatever state was chosen.
    if (bump_s) begin
      tries_d = tries_q + 8'd1;
      if (tries_d == MAX_L) begin
        state_d = FAIL;
      end else begin
        state_d = state_d;
      end
    end else begin
      tries_d = tries_d;
    end
  end

  // State and output registers; outputs are derived from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q   <= IDLE;
      tries_q   <= 8'd0;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      occ_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      valid_q   <= 1'b0;
      food_x_q  <= '0;
      food_y_q  <= '0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
      occ_req_q <= (state_d == QUERY);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      fail_q    <= (state_d == FAIL);
      if (state_d == DONE) begin
        food_x_q <= cand_x_q;
        food_y_q <= cand_y_q;
        valid_q  <= 1'b1;
      end else if (state_q == IDLE && spawn_req) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign occ_req    = occ_req_q;
  assign occ_x      = cand_x_q;
  assign occ_y      = cand_y_q;
  assign busy       = busy_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = valid_q;
  assign food_done  = done_q;
  assign food_fail  = fail_q;

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: default grid instance (a) and a COLS=24,
// MAX_TRIES=4 instance (b) sharing clock, reset, rnd and occupancy inputs.
module tb_food_spawner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, occ_ack, occ_hit, spawn_a, spawn_b;
  logic [6:0] rnd;
  logic       a_occ_req, a_busy, a_food_valid, a_food_done, a_food_fail;
  logic [4:0] a_occ_x, a_occ_y, a_food_x, a_food_y;
  logic       b_occ_req, b_busy, b_food_valid, b_food_done, b_food_fail;
  logic [4:0] b_occ_x, b_occ_y, b_food_x, b_food_y;
  int checks = 0;
  int errors = 0;

  food_spawner dut_a (
    .clock_25(clk), .reset(reset), .rnd(rnd), .spawn_req(spawn_a),
    .occ_req(a_occ_req), .occ_x(a_occ_x), .occ_y(a_occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit), .busy(a_busy),
    .food_x(a_food_x), .food_y(a_food_y), .food_valid(a_food_valid),
    .food_done(a_food_done), .food_fail(a_food_fail)
  );

  food_spawner #(.COLS(24), .MAX_TRIES(4)) dut_b (
    .clock_25(clk), .reset(reset), .rnd(rnd), .spawn_req(spawn_b),
    .occ_req(b_occ_req), .occ_x(b_occ_x), .occ_y(b_occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit), .busy(b_busy),
    .food_x(b_food_x), .food_y(b_food_y), .food_valid(b_food_valid),
    .food_done(b_food_done), .food_fail(b_food_fail)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; rnd = 7'd0; occ_ack = 1'b0; occ_hit = 1'b0;
    spawn_a = 1'b0; spawn_b = 1'b0;
    tick; tick;
    reset = 1'b0;
    checks++;
    if ({a_busy, a_occ_req, a_food_valid, a_food_done, a_food_fail} !== 5'b0) begin
      errors++; $display("FAIL reset_a_flags: got %b expected 00000",
        {a_busy, a_occ_req, a_food_valid, a_food_done, a_food_fail});
    end
    checks++;
    if ({b_busy, b_occ_req, b_food_valid, b_food_done, b_food_fail} !== 5'b0) begin
      errors++; $display("FAIL reset_b_flags: got %b expected 00000",
        {b_busy, b_occ_req, b_food_valid, b_food_done, b_food_fail});
    end
    checks++;
    if ({a_food_x, a_food_y} !== 10'd0) begin
      errors++; $display("FAIL reset_food_xy: got %0d,%0d expected 0,0", a_food_x, a_food_y);
    end
  endtask

  task automatic test_basic;
    spawn_a = 1'b1; rnd = 7'd99; tick;
    spawn_a = 1'b0; rnd = 7'd5;
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", a_busy); end
    tick; rnd = 7'd7; tick;
    checks++;
    if ({a_occ_req, a_occ_x, a_occ_y} !== {1'b1, 5'd5, 5'd7}) begin
      errors++; $display("FAIL basic_query: got req=%b x=%0d y=%0d expected req=1 x=5 y=7",
        a_occ_req, a_occ_x, a_occ_y);
    end
    occ_ack = 1'b1; occ_hit = 1'b0; tick;
    checks++;
    if ({a_food_done, a_food_valid, a_food_x, a_food_y} !== {1'b1, 1'b1, 5'd5, 5'd7}) begin
      errors++; $display("FAIL basic_done: got done=%b valid=%b x=%0d y=%0d expected 1 1 5 7",
        a_food_done, a_food_valid, a_food_x, a_food_y);
    end
    occ_ack = 1'b0; tick;
    checks++;
    if ({a_food_done, a_busy, a_food_valid} !== 3'b001) begin
      errors++; $display("FAIL basic_after: got done/busy/valid=%b expected 001",
        {a_food_done, a_busy, a_food_valid});
    end
  endtask

  task automatic test_reset_mid_query;
    spawn_a = 1'b1; tick;
    spawn_a = 1'b0; rnd = 7'd3; tick; rnd = 7'd4; tick;
    checks++;
    if (a_occ_req !== 1'b1) begin errors++; $display("FAIL midq_req: got %b expected 1", a_occ_req); end
    reset = 1'b1; tick;
    checks++;
    if ({a_busy, a_occ_req, a_food_valid, a_food_done, a_food_fail} !== 5'b0) begin
      errors++; $display("FAIL midq_reset: got %b expected 00000",
        {a_busy, a_occ_req, a_food_valid, a_food_done, a_food_fail});
    end
    reset = 1'b0; tick;
    checks++;
    if ({a_busy, a_food_done, a_food_fail} !== 3'b000) begin
      errors++; $display("FAIL midq_after: got %b expected 000", {a_busy, a_food_done, a_food_fail});
    end
  endtask

  task automatic test_y_reject;
    spawn_a = 1'b1; tick;
    spawn_a = 1'b0; rnd = 7'd5; tick; rnd = 7'd30; tick; rnd = 7'd10;
    checks++;
    if (a_occ_req !== 1'b0) begin errors++; $display("FAIL yrej_no_query: got %b expected 0", a_occ_req); end
    tick;
    checks++;
    if ({a_occ_req, a_occ_x, a_occ_y} !== {1'b1, 5'd5, 5'd10}) begin
      errors++; $display("FAIL yrej_query: got req=%b x=%0d y=%0d expected 1 5 10",
        a_occ_req, a_occ_x, a_occ_y);
    end
    occ_ack = 1'b1; occ_hit = 1'b0; tick;
    checks++;
    if ({a_food_done, a_food_x, a_food_y} !== {1'b1, 5'd5, 5'd10}) begin
      errors++; $display("FAIL yrej_done: got done=%b x=%0d y=%0d expected 1 5 10",
        a_food_done, a_food_x, a_food_y);
    end
    occ_ack = 1'b0; tick;
  endtask

  task automatic test_retry;
    spawn_a = 1'b1; tick;
    spawn_a = 1'b0;
    checks++;
    if (a_food_valid !== 1'b0) begin errors++; $display("FAIL retry_valid_clr: got %b expected 0", a_food_valid); end
    rnd = 7'd5; tick; rnd = 7'd7; tick;
    occ_ack = 1'b1; occ_hit = 1'b1; rnd = 7'd9; tick;
    checks++;
    if ({a_occ_req, a_food_done, a_busy} !== 3'b001) begin
      errors++; $display("FAIL retry_rearm: got req/done/busy=%b expected 001",
        {a_occ_req, a_food_done, a_busy});
    end
    occ_ack = 1'b0; occ_hit = 1'b0; tick; rnd = 7'd3; tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({a_occ_req, a_occ_x, a_occ_y} !== {1'b1, 5'd9, 5'd3}) begin
        errors++; $display("FAIL retry_stable: wait %0d got req=%b x=%0d y=%0d expected 1 9 3",
          i, a_occ_req, a_occ_x, a_occ_y);
      end
      rnd = 7'($urandom_range(0, 127)); occ_hit = 1'b1; tick;
    end
    occ_ack = 1'b1; occ_hit = 1'b0; tick;
    checks++;
    if ({a_food_done, a_food_valid, a_food_x, a_food_y} !== {1'b1, 1'b1, 5'd9, 5'd3}) begin
      errors++; $display("FAIL retry_done: got done=%b valid=%b x=%0d y=%0d expected 1 1 9 3",
        a_food_done, a_food_valid, a_food_x, a_food_y);
    end
    occ_ack = 1'b0; tick;
  endtask

  task automatic test_fail_hits;
    int fail_at, fail_cnt, done_cnt;
    logic busy_late;
    fail_at = 0; fail_cnt = 0; done_cnt = 0; busy_late = 1'b1;
    occ_ack = 1'b1; occ_hit = 1'b1; rnd = 7'd5;
    spawn_b = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick;
      spawn_b = (i == 4);
      if (b_food_fail) begin
        fail_cnt++;
        if (fail_at == 0) fail_at = i;
      end
      if (b_food_done) done_cnt++;
      if (i == 14) busy_late = b_busy;
    end
    occ_ack = 1'b0; occ_hit = 1'b0; spawn_b = 1'b0;
    checks++;
    if (fail_at != 13) begin errors++; $display("FAIL hits_fail_cycle: got %0d expected 13", fail_at); end
    checks++;
    if (fail_cnt != 1 || done_cnt != 0) begin
      errors++; $display("FAIL hits_pulses: got fail=%0d done=%0d expected 1 0", fail_cnt, done_cnt);
    end
    checks++;
    if ({busy_late, b_busy, b_food_valid} !== 3'b000) begin
      errors++; $display("FAIL hits_idle: got %b expected 000", {busy_late, b_busy, b_food_valid});
    end
  endtask

  task automatic test_all_reject;
    int fa, fb, fa_cnt, done_cnt;
    fa = 0; fb = 0; fa_cnt = 0; done_cnt = 0;
    rnd = 7'h7F; spawn_a = 1'b1; spawn_b = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick;
      spawn_a = 1'b0; spawn_b = 1'b0;
      if (a_food_fail) begin fa_cnt++; if (fa == 0) fa = i; end
      if (b_food_fail && fb == 0) fb = i;
      if (a_food_done || b_food_done) done_cnt++;
    end
    checks++;
    if (fb != 5) begin errors++; $display("FAIL rej_x_fail_cycle: got %0d expected 5", fb); end
    checks++;
    if (fa != 66) begin errors++; $display("FAIL rej_y_fail_cycle: got %0d expected 66", fa); end
    checks++;
    if (fa_cnt != 1 || done_cnt != 0) begin
      errors++; $display("FAIL rej_pulses: got fail=%0d done=%0d expected 1 0", fa_cnt, done_cnt);
    end
    checks++;
    if ({a_food_valid, b_food_valid, a_busy, b_busy} !== 4'b0) begin
      errors++; $display("FAIL rej_idle: got %b expected 0000",
        {a_food_valid, b_food_valid, a_busy, b_busy});
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reset_mid_query;
    test_y_reject;
    test_retry;
    test_fail_hits;
    test_all_reject;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
